ctrl_pipe_reg: RTL
==================

CTRL_PIPE_REG -- requirements
Module: ctrl_pipe_reg

Interface
REQ-001 Parameter WIDTH, default 4, width in bits of the control word carried per stage; legal range 1..64.
REQ-002 Parameter STAGES, default 1, number of register stages in the chain; legal range 1..4.
REQ-003 Parameter CNT_W, default 16, width of each statistics counter; legal range 4..32.
REQ-004 Port clk, input, 1, clock; all state updates on rising edge.
REQ-005 Port reset, input, 1, reset; asynchronous, active-high.
REQ-006 Port ctrl_in, input, WIDTH, control word from the upstream stage, e.g. {RegWrite, ResultSrc[1:0], MemWrite}.
REQ-007 Port valid_in, input, 1, ctrl_in carries a real instruction.
REQ-008 Port stall, input, 1, freeze the whole chain this cycle.
REQ-009 Port flush, input, 1, kill every stage this cycle.
REQ-010 Port ctrl_out, output, WIDTH, control word of the last stage.
REQ-011 Port valid_out, output, 1, last stage holds a real instruction.
REQ-012 Port ctrl_tap, output, STAGES*WIDTH, gated control word of every stage; stage 0 in bits [WIDTH-1:0].
REQ-013 Port valid_tap, output, STAGES, valid bit of every stage; stage 0 in bit 0.
REQ-014 Port stall_cnt, output, CNT_W, saturating count of stalled cycles.
REQ-015 Port flush_cnt, output, CNT_W, saturating count of flush cycles that killed at least one valid stage.

Function
REQ-016 Each stage k SHALL hold a WIDTH-bit word w[k] and a valid bit v[k].
REQ-017 Normal advance (stall=0, flush=0) SHALL load w[0]<=ctrl_in and v[0]<=valid_in, and for k>=1 load w[k]<=w[k-1] and v[k]<=v[k-1].
REQ-018 Latency from ctrl_in to ctrl_out SHALL be exactly STAGES cycles when no stall or flush occurs.
REQ-019 Stall (stall=1, flush=0) SHALL leave every w[k] and v[k] unchanged.
REQ-020 Flush (flush=1) SHALL clear every v[k] and every w[k] to 0 on the next edge, regardless of stall.
REQ-021 Flush SHALL also discard ctrl_in/valid_in in that cycle; no bubble from upstream survives a flush.
REQ-022 Output gating: ctrl_tap stage k SHALL be w[k] when v[k]=1, else all zeros; ctrl_out SHALL equal ctrl_tap stage STAGES-1.
REQ-023 Because of REQ-022, an invalid stage SHALL never present a nonzero control bit, so RegWrite and MemWrite are never asserted by a bubble.
REQ-024 valid_out SHALL equal v[STAGES-1]; valid_tap bit k SHALL equal v[k].
REQ-025 ctrl_in SHALL be sampled only when valid_in=1 matters for outputs; a word captured with valid_in=0 is stored but SHALL be masked by REQ-022.
REQ-026 stall_cnt SHALL increment by 1 on each edge with stall=1 and flush=0, and hold at 2^CNT_W-1 once reached.
REQ-027 flush_cnt SHALL increment by 1 on each edge with flush=1 and any v[k]=1 before the edge, and hold at 2^CNT_W-1 once reached.
REQ-028 Stall and flush asserted together SHALL count as a flush only (REQ-020, REQ-027); stall_cnt is unchanged.
REQ-029 All outputs SHALL be driven directly from registers or the AND-gating of REQ-022; no combinational path from any input to any output.

Reset
REQ-030 reset=1 SHALL asynchronously clear all w[k], v[k], stall_cnt and flush_cnt to 0, so ctrl_out=0, valid_out=0, ctrl_tap=0, valid_tap=0.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight words; the first edge after deassertion applies REQ-017 to REQ-021 normally.

Verification
REQ-032 STAGES=3, WIDTH=4, inputs 4'hA,4'h5,4'hF valid on three consecutive cycles, no stall -> ctrl_out shows 4'hA,4'h5,4'hF on cycles 3,4,5 with valid_out=1.
REQ-033 STAGES=2, load 4'h9 valid, then stall for 5 cycles -> ctrl_tap frozen for all 5 cycles, stall_cnt=5, then normal advance resumes.
REQ-034 STAGES=3, fill all stages valid with 4'hF, assert flush and stall together -> next cycle valid_tap=3'b000, ctrl_tap=0, flush_cnt=1, stall_cnt=0.
REQ-035 Flush with all stages already invalid -> flush_cnt unchanged; valid_in=0 with ctrl_in=4'hF -> ctrl_out=4'h0 after STAGES cycles.
REQ-036 CNT_W=4, stall held 20 cycles -> stall_cnt saturates at 15 and stays there.
REQ-037 Assert reset asynchronously between clock edges with a full pipeline -> all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/ctrl_pipe_reg.sv
// ctrl_pipe_reg: a chain of STAGES control-word registers with per-stage valid bits.
// - stall freezes the whole chain.
// - flush clears every stage and discards this cycle's input.
// - Invalid stages present all-zero control words, so a bubble can never assert
//   RegWrite or MemWrite downstream.
// - Two saturating counters record stalled cycles and flushes that killed real work.
module ctrl_pipe_reg #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          ctrl_in,
  input  logic                      valid_in,
  input  logic                      stall,
  input  logic                      flush,
  output logic [WIDTH-1:0]          ctrl_out,
  output logic                      valid_out,
  output logic [STAGES*WIDTH-1:0]   ctrl_tap,
  output logic [STAGES-1:0]         valid_tap,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  // What the chain does on the coming edge; flush outranks stall.
  typedef enum logic [1:0] {
    OP_ADVANCE,
    OP_STALL,
    OP_FLUSH
  } pipe_op_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  pipe_op_e             op;
  logic [WIDTH-1:0]     w_q [STAGES];
  logic [WIDTH-1:0]     w_d [STAGES];
  logic [STAGES-1:0]    v_q;
  logic [STAGES-1:0]    v_d;
  logic [CNT_W-1:0]     stall_cnt_q;
  logic [CNT_W-1:0]     stall_cnt_d;
  logic [CNT_W-1:0]     flush_cnt_q;
  logic [CNT_W-1:0]     flush_cnt_d;

  // Decode the per-cycle operation from stall/flush.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first; a path
    // that leaves it unassigned would otherwise infer a latch.
    op = OP_ADVANCE;
    if (flush) begin
      op = OP_FLUSH;
    end else if (stall) begin
      op = OP_STALL;
    end
  end

  // Next word and valid bit of every stage.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_d[k] = w_q[k];
    end
    v_d = v_q;

    unique case (op)
      OP_ADVANCE: begin
        w_d[0] = ctrl_in;
        v_d[0] = valid_in;
        for (int k = 1; k < STAGES; k++) begin
          w_d[k] = w_q[k-1];
          v_d[k] = v_q[k-1];
        end
      end
      OP_STALL: begin
        // Hold everything; the defaults above already do that.
      end
      OP_FLUSH: begin
        // The incoming word is dropped too, so nothing survives the flush.
        for (int k = 0; k < STAGES; k++) begin
          w_d[k] = '0;
        end
        v_d = '0;
      end
      default: begin
      end
    endcase
  end

  // Saturating statistics counters.
  // A combined stall+flush counts only as a flush. A flush counts only if it
  // killed at least one valid stage.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (op == OP_STALL && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (op == OP_FLUSH && (|v_q) && flush_cnt_q != CNT_MAX) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the stage array is a few flops rather than a RAM, so it is reset
      // as well. This lets reset discard in-flight words outright instead of
      // relying on the valid bits alone.
      for (int k = 0; k < STAGES; k++) begin
        w_q[k] <= '0;
      end
      v_q         <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every stage then
      // samples its neighbour's pre-edge value, which is what makes the chain
      // shift instead of collapsing.
      for (int k = 0; k < STAGES; k++) begin
        w_q[k] <= w_d[k];
      end
      v_q         <= v_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Output gating: a stage shows its word only while it holds a real instruction.
  always_comb begin
    ctrl_tap = '0;
    for (int k = 0; k < STAGES; k++) begin
      ctrl_tap[k*WIDTH +: WIDTH] = w_q[k] & {WIDTH{v_q[k]}};
    end
  end

  assign ctrl_out  = ctrl_tap[(STAGES-1)*WIDTH +: WIDTH];
  assign valid_out = v_q[STAGES-1];
  assign valid_tap = v_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
